memory_arbiter: RTL and testbench

//  Round-robin arbiter upstream of memory_controller. Four clients (fetch, decode, execute, writeback) raise

---
 rtl/memory_arbiter.sv | 176 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//   Round-robin arbiter in front of memory_controller. Four clients (0 fetch,
//   1 decode, 2 execute, 3 writeback) raise requests. One winner is granted and
//   drives the controller control lines for ACCESS_CYCLES cycles. Read data is
//   then captured, and the winner gets a one-cycle ack. Client address and
//   write-data buses bypass this block; only control is generated here.
//
// Ports
//   clk_i        system clock, all state on rising edge
//   reset_i      asynchronous active-high reset
//   req_i[3:0]   per-client request, held until the matching ack
//   we_i[3:0]    per-client op (1 = write, 0 = read), sampled at grant
//   mem_rdata_i  read data from the controller
//   mc_en_o      controller enable
//   mc_sel_o     controller port select
//   mc_read_o    controller read0..read3
//   mc_write_o   controller write0..write3
//   ack_o        one-cycle completion pulse to the granted client
//   rd_data_o    data of the last completed read
//   busy_o       high while a transaction is in ACCESS or RESP
// -----------------------------------------------------------------------------
module memory_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [3:0]            req_i,
  input  logic [3:0]            we_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  mc_en_o,
  output logic [1:0]            mc_sel_o,
  output logic [3:0]            mc_read_o,
  output logic [3:0]            mc_write_o,
  output logic [3:0]            ack_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            k_q, k_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  // Registered output copies
  logic                  en_q, en_d;
  logic [1:0]            sel_q, sel_d;
  logic [3:0]            read_q, read_d;
  logic [3:0]            write_q, write_d;
  logic [3:0]            ack_q, ack_d;
  logic                  busy_q, busy_d;

  // Round-robin pick: the first requesting client at or after ptr, wrapping.
  logic [1:0] win;
  logic [1:0] scan_idx;
  logic       found;

  always_comb begin
    win      = ptr_q;
    scan_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!found && req_i[scan_idx]) begin
        win   = scan_idx;
        found = 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    we_d      = we_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          k_d     = win;
          we_d    = we_i[win];
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            rd_data_d = mem_rdata_i;
          end
          // ptr only moves on a transaction that reaches completion
          ptr_d   = k_q + 2'd1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state they describe.
  logic acc_d;
  logic resp_d;

  assign acc_d   = (state_d == ACCESS);
  assign resp_d  = (state_d == RESP);
  assign en_d    = acc_d;
  assign sel_d   = acc_d ? k_d : 2'd0;
  assign busy_d  = (state_d != IDLE);

  for (genvar gi = 0; gi < 4; gi++) begin : g_port
    assign read_d[gi]  = acc_d && !we_d && (k_d == 2'(gi));
    assign write_d[gi] = acc_d &&  we_d && (k_d == 2'(gi));
    assign ack_d[gi]   = resp_d && (k_d == 2'(gi));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      k_q       <= '0;
      we_q      <= 1'b0;
      rd_data_q <= '0;
      en_q      <= 1'b0;
      sel_q     <= '0;
      read_q    <= '0;
      write_q   <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      we_q      <= we_d;
      rd_data_q <= rd_data_d;
      en_q      <= en_d;
      sel_q     <= sel_d;
      read_q    <= read_d;
      write_q   <= write_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign mc_en_o    = en_q;
  assign mc_sel_o   = sel_q;
  assign mc_read_o  = read_q;
  assign mc_write_o = write_q;
  assign ack_o      = ack_q;
  assign rd_data_o  = rd_data_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//   Two arbiters: instance 0 with ACCESS_CYCLES=1 and instance 1 with
//   ACCESS_CYCLES=3. A transaction-level model tracks where each instance is
//   in its grant timeline. Outputs are compared every cycle on the falling
//   edge, and directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req   [2];
  logic [3:0] we    [2];
  logic [7:0] rdata [2];

  logic       en    [2];
  logic [1:0] sel   [2];
  logic [3:0] rd_b  [2];
  logic [3:0] wr_b  [2];
  logic [3:0] ack   [2];
  logic [7:0] rdout [2];
  logic       busy  [2];

  int total = 0;
  int bad   = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    memory_arbiter #(
      .DATA_WIDTH   (8),
      .ACCESS_CYCLES(gi == 0 ? 1 : 3)
    ) u_dut (
      .clk_i      (clk),
      .reset_i    (rst),
      .req_i      (req[gi]),
      .we_i       (we[gi]),
      .mem_rdata_i(rdata[gi]),
      .mc_en_o    (en[gi]),
      .mc_sel_o   (sel[gi]),
      .mc_read_o  (rd_b[gi]),
      .mc_write_o (wr_b[gi]),
      .ack_o      (ack[gi]),
      .rd_data_o  (rdout[gi]),
      .busy_o     (busy[gi])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  // m_ph: 0 idle, 1..AC = access cycle number, AC+1 = ack cycle
  int         m_ph  [2];
  int         m_k   [2];
  bit         m_w   [2];
  int         m_ptr [2];
  logic [7:0] m_rd  [2];

  function automatic int ac_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_ph[i]  = 0;
        m_k[i]   = 0;
        m_w[i]   = 0;
        m_ptr[i] = 0;
        m_rd[i]  = 8'h00;
      end else if (m_ph[i] == 0) begin
        if (req[i] != 4'b0000) begin
          // scan backwards so the last hit is the first one in rotation order
          for (int j = 3; j >= 0; j--) begin
            if (req[i][(m_ptr[i] + j) % 4]) m_k[i] = (m_ptr[i] + j) % 4;
          end
          m_w[i]  = we[i][m_k[i]];
          m_ph[i] = 1;
        end
      end else if (m_ph[i] <= ac_of(i)) begin
        if (m_ph[i] == ac_of(i)) begin
          if (!m_w[i]) m_rd[i] = rdata[i];
          m_ptr[i] = (m_k[i] + 1) % 4;
        end
        m_ph[i] = m_ph[i] + 1;
      end else begin
        m_ph[i] = 0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      bit         e_en;
      logic [3:0] one;
      e_en = (m_ph[i] >= 1) && (m_ph[i] <= ac_of(i));
      one  = 4'b0001 << m_k[i];
      chk($sformatf("mc_en[%0d]", i),    32'(en[i]),    32'(e_en));
      chk($sformatf("mc_sel[%0d]", i),   32'(sel[i]),   e_en ? 32'(m_k[i]) : 32'd0);
      chk($sformatf("mc_read[%0d]", i),  32'(rd_b[i]),  (e_en && !m_w[i]) ? 32'(one) : 32'd0);
      chk($sformatf("mc_write[%0d]", i), 32'(wr_b[i]),  (e_en &&  m_w[i]) ? 32'(one) : 32'd0);
      chk($sformatf("ack[%0d]", i),      32'(ack[i]),   (m_ph[i] == ac_of(i) + 1) ? 32'(one) : 32'd0);
      chk($sformatf("rd_data[%0d]", i),  32'(rdout[i]), 32'(m_rd[i]));
      chk($sformatf("busy[%0d]", i),     32'(busy[i]),  32'(m_ph[i] != 0));
    end
  endtask

  // Compare on the falling edge, then return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input int i, output logic [3:0] a);
    a = 4'b0000;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (ack[i] != 4'b0000) begin
        a = ack[i];
        $display("txn inst=%0d ack=%b rd_data=%h", i, a, rdout[i]);
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL ack_timeout inst=%0d actual=none required=ack within 12 cycles", i);
  endtask

  function automatic int idx_of(input logic [3:0] a);
    int r;
    r = -1;
    for (int b = 0; b < 4; b++) if (a[b]) r = b;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] a;
    int         exp_order [5];
    int         n_en;
    int         ack_k;
    bit         saw_w;

    exp_order = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i]   = 4'b0000;
      we[i]    = 4'b0000;
      rdata[i] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #2;
    chk("reset_en", 32'(en[0]), 32'd0);
    chk("reset_busy", 32'(busy[0]), 32'd0);
    chk("reset_rd", 32'(rdout[1]), 32'd0);
    rst = 1'b0;
    tick();

    // Reset in the middle of ACCESS
    req[0] = 4'b0010;
    tick();
    chk("t1_sel_before_rst", 32'(sel[0]), 32'd1);
    chk("t1_en_before_rst", 32'(en[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("t1_rst_en", 32'(en[0]), 32'd0);
    chk("t1_rst_read", 32'(rd_b[0]), 32'd0);
    chk("t1_rst_busy", 32'(busy[0]), 32'd0);
    chk("t1_rst_ack", 32'(ack[0]), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t1_regrant_sel", 32'(sel[0]), 32'd1);
    tick();
    chk("t1_ack", 32'(ack[0]), 32'h2);
    $display("txn t1 reset/regrant ack=%b", ack[0]);
    req[0] = 4'b0000;
    tick();
    chk("t1_idle_busy", 32'(busy[0]), 32'd0);

    // Fairness from a fresh ptr=0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    req[0] = 4'b1111;
    we[0]  = 4'b0000;
    rdata[0] = 8'h77;
    for (int n = 0; n < 5; n++) begin
      wait_ack(0, a);
      chk("fair_grant", 32'(idx_of(a)), 32'(exp_order[n]));
      req[0] = 4'b1111 & ~a;
      tick();
      chk("fair_ack_one_cycle", 32'(ack[0]), 32'd0);
      req[0] = 4'b1111;
    end
    req[0] = 4'b0000;
    tick();
    tick();

    // Single read by client 2 (ptr is 1 here)
    req[0] = 4'b0100;
    we[0]  = 4'b0000;
    rdata[0] = 8'hA5;
    tick();
    chk("t2_en", 32'(en[0]), 32'd1);
    chk("t2_sel", 32'(sel[0]), 32'd2);
    chk("t2_read", 32'(rd_b[0]), 32'h4);
    tick();
    chk("t2_ack", 32'(ack[0]), 32'h4);
    chk("t2_rd_data", 32'(rdout[0]), 32'hA5);
    chk("t2_en_low", 32'(en[0]), 32'd0);
    $display("txn t2 read ack=%b rd_data=%h", ack[0], rdout[0]);
    req[0] = 4'b0000;
    tick();
    chk("t2_idle", 32'(busy[0]), 32'd0);

    // ptr=3, clients 0 and 3 requesting: 3 writes first, then 0 reads
    req[0] = 4'b1001;
    we[0]  = 4'b1000;
    rdata[0] = 8'hEE;
    tick();
    chk("t6_sel3", 32'(sel[0]), 32'd3);
    chk("t4_write", 32'(wr_b[0]), 32'h8);
    chk("t4_no_read", 32'(rd_b[0]), 32'd0);
    tick();
    chk("t4_wr_ack", 32'(ack[0]), 32'h8);
    chk("t4_rd_kept", 32'(rdout[0]), 32'hA5);
    $display("txn t4 write ack=%b rd_data=%h", ack[0], rdout[0]);
    req[0] = 4'b0001;
    we[0]  = 4'b0000;
    rdata[0] = 8'h5A;
    tick();
    tick();
    chk("t6_sel0", 32'(sel[0]), 32'd0);
    chk("t6_read0", 32'(rd_b[0]), 32'h1);
    tick();
    chk("t6_ack0", 32'(ack[0]), 32'h1);
    chk("t6_rd", 32'(rdout[0]), 32'h5A);
    $display("txn t6 read ack=%b rd_data=%h", ack[0], rdout[0]);
    req[0] = 4'b1000;
    rdata[0] = 8'h3C;
    tick();
    tick();
    chk("t4_read_sel", 32'(sel[0]), 32'd3);
    chk("t4_read_bits", 32'(rd_b[0]), 32'h8);
    tick();
    chk("t4_read_ack", 32'(ack[0]), 32'h8);
    chk("t4_rd_3c", 32'(rdout[0]), 32'h3C);
    $display("txn t4 read ack=%b rd_data=%h", ack[0], rdout[0]);
    req[0] = 4'b0000;
    tick();

    // ACCESS_CYCLES=3 instance: committed grant, ack in cycle E+4
    req[1] = 4'b0001;
    we[1]  = 4'b0000;
    rdata[1] = 8'hC3;
    tick();
    chk("t5_en_first", 32'(en[1]), 32'd1);
    chk("t5_sel", 32'(sel[1]), 32'd0);
    we[1]  = 4'b1111;
    req[1] = 4'b1110;
    n_en  = 0;
    ack_k = 0;
    saw_w = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (en[1]) n_en++;
      if (wr_b[1] != 4'b0000) saw_w = 1'b1;
      if (ack[1] != 4'b0000 && ack_k == 0) begin
        ack_k = k;
        chk("t5_ack_bits", 32'(ack[1]), 32'h1);
        chk("t5_rd", 32'(rdout[1]), 32'hC3);
        $display("txn t5 ack=%b cycle=E+%0d rd_data=%h", ack[1], k, rdout[1]);
        req[1] = 4'b0000;
      end
      tick();
    end
    chk("t5_en_cycles", 32'(n_en), 32'd3);
    chk("t5_ack_cycle", 32'(ack_k), 32'd4);
    chk("t5_no_write", 32'(saw_w), 32'd0);
    we[1] = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
